// File: rtl/estimador_row_issue_acc.sv
// ============================================================================
// estimador_row_issue_acc
// Issues one mvmult row call per request and saturating-accumulates its results
// Rev 1.0
// ============================================================================
`default_nettype none

module estimador_row_issue_acc #(
  parameter int W       = 21,
  parameter int TIMEOUT = 15
) (
  input  logic         ap_clk,
  input  logic         ap_rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_u,
  input  logic         clr,
  output logic         sub_start,
  input  logic         sub_ready,
  input  logic         sub_done,
  input  logic         sub_idle,
  output logic [W-1:0] sub_u,
  input  logic [W-1:0] sub_y0,
  input  logic [W-1:0] sub_y1,
  input  logic [W-1:0] sub_y2,
  input  logic         sub_y0_vld,
  input  logic         sub_y1_vld,
  input  logic         sub_y2_vld,
  output logic [W-1:0] x0,
  output logic [W-1:0] x1,
  output logic [W-1:0] x2,
  output logic         x_valid,
  output logic         busy,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_ACC   = 3'd3,
    S_PULSE = 3'd4
  } state_t;

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t                state_q, state_d;
  logic [2:0][W-1:0]     x_q, x_d;
  logic [2:0][W-1:0]     cap_q, cap_d;
  logic [2:0]            flag_q, flag_d;
  logic [W-1:0]          sub_u_q, sub_u_d;
  logic                  err_q, err_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [2:0][W-1:0]     y_in;
  logic [2:0]            vld_in;
  logic [2:0]            flag_now;
  logic [CW-1:0]         cnt_inc;

  assign y_in     = {sub_y2, sub_y1, sub_y0};
  assign vld_in   = {sub_y2_vld, sub_y1_vld, sub_y0_vld};
  assign flag_now = flag_q | vld_in;
  assign cnt_inc  = cnt_q + CNT_ONE;

  // Sign-extend to W+1 bits; a carry that disagrees with the sign bit is overflow.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1])
      sat_add = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      sat_add = s[W-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cap_d   = cap_q;
    flag_d  = flag_q;
    sub_u_d = sub_u_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (clr) begin
          x_d   = '0;
          err_d = 1'b0;
        end else if (req_valid && req_ready) begin
          sub_u_d = req_u;
          flag_d  = 3'b000;
          state_d = S_START;
        end
      end
      S_START: begin
        // ready takes priority; done without ready is a protocol violation
        if (sub_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else if (sub_done) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        for (int k = 0; k < 3; k++) begin
          if (vld_in[k]) cap_d[k] = y_in[k];
        end
        flag_d = flag_now;
        cnt_d  = cnt_inc;
        if (sub_done) begin
          if (&flag_now) begin
            state_d = S_ACC;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (cnt_inc == CNT_MAX) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ACC: begin
        for (int k = 0; k < 3; k++) begin
          x_d[k] = sat_add(x_q[k], cap_q[k]);
        end
        state_d = S_PULSE;
      end
      S_PULSE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      cap_q   <= '0;
      flag_q  <= 3'b000;
      sub_u_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cap_q   <= cap_d;
      flag_q  <= flag_d;
      sub_u_q <= sub_u_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready = (state_q == S_IDLE) && !clr && sub_idle;
  assign sub_start = (state_q == S_START);
  assign x_valid   = (state_q == S_PULSE);
  assign busy      = (state_q != S_IDLE);
  assign sub_u     = sub_u_q;
  assign err       = err_q;
  assign x0        = x_q[0];
  assign x1        = x_q[1];
  assign x2        = x_q[2];

endmodule

`default_nettype wire
